// File: rtl/mem_io_responder_if.sv
// Bus, loader and port signals between the CPU-side controller and the memory responder.
// Pure wiring, no latency.
// Output port uses valid/ready; input port uses valid/ready with the responder holding one byte.
interface mem_io_responder_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic [7:0] rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       cpu_rst;

    // Controller / loader / port peers side
    modport master (
        output addr, wdata, write, out_ready, in_data, in_valid,
               load_en, load_addr, load_data,
        input  rdata, out_data, out_valid, in_ready, cpu_rst
    );

    // Responder side
    modport slave (
        input  addr, wdata, write, out_ready, in_data, in_valid,
               load_en, load_addr, load_data,
        output rdata, out_data, out_valid, in_ready, cpu_rst
    );
endinterface

// File: rtl/mem_io_responder.sv
// 256x8 RAM responder with an overlaid I/O page (OUT, IN, STATUS, TIMER) and a boot loader port.
// Reads are combinational (zero latency); writes and flag updates take effect on the clk edge.
// Output port holds one byte until out_ready; input port refuses new data (in_ready=0) while full.
module mem_io_responder #(
    parameter logic [7:0] IO_BASE = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    mem_io_responder_if.slave bus
);
    localparam logic [7:0] ADDR_OUT    = IO_BASE;
    localparam logic [7:0] ADDR_IN     = IO_BASE + 8'd1;
    localparam logic [7:0] ADDR_STATUS = IO_BASE + 8'd2;
    localparam logic [7:0] ADDR_TIMER  = IO_BASE + 8'd3;

    logic [7:0] mem [256];
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] in_hold;
    logic       in_full;
    logic       overrun;
    logic [7:0] timer;
    logic       cpu_rst;

    // A bus write only counts when the loader is idle; the loader owns RAM otherwise.
    logic bus_wr;
    logic is_io;
    assign bus_wr = bus.write && !bus.load_en;
    assign is_io  = (bus.addr >= IO_BASE);

    // RAM write port: loader has priority and reaches every location, including the shadowed I/O range.
    always_ff @(posedge clk) begin
        if (bus.load_en)
            mem[bus.load_addr] <= bus.load_data;
        else if (bus.write && !is_io)
            mem[bus.addr] <= bus.wdata;
    end

    // I/O page registers, port handshakes, timer and CPU reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            in_hold   <= 8'h00;
            in_full   <= 1'b0;
            overrun   <= 1'b0;
            timer     <= 8'h00;
            cpu_rst   <= 1'b1;
        end else begin
            cpu_rst <= bus.load_en;

            // Consumer took the byte; out_data keeps its last value for readback.
            if (out_valid && bus.out_ready)
                out_valid <= 1'b0;

            if (bus_wr && bus.addr == ADDR_OUT) begin
                if (out_valid)
                    overrun <= 1'b1;
                else begin
                    out_data  <= bus.wdata;
                    out_valid <= 1'b1;
                end
            end

            // Status clears; an offer arriving while full is not taken this edge because in_ready was low.
            if (bus_wr && bus.addr == ADDR_STATUS) begin
                if (bus.wdata[0])
                    in_full <= 1'b0;
                if (bus.wdata[2])
                    overrun <= 1'b0;
            end

            if (bus.in_valid && !in_full) begin
                in_hold <= bus.in_data;
                in_full <= 1'b1;
            end

            // A timer write replaces this cycle's increment.
            if (bus_wr && bus.addr == ADDR_TIMER)
                timer <= bus.wdata;
            else
                timer <= timer + 8'd1;
        end
    end

    // Combinational read mux; reads never change state.
    always_comb begin
        bus.rdata = 8'h00;
        if (!is_io)
            bus.rdata = mem[bus.addr];
        else if (bus.addr == ADDR_OUT)
            bus.rdata = out_data;
        else if (bus.addr == ADDR_IN)
            bus.rdata = in_hold;
        else if (bus.addr == ADDR_STATUS)
            bus.rdata = {5'b0, overrun, out_valid, in_full};
        else if (bus.addr == ADDR_TIMER)
            bus.rdata = timer;
    end

    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = !in_full;
    assign bus.cpu_rst   = cpu_rst;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder: loader, RAM, output/input ports, timer, async reset.
module tb_mem_io_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_io_responder_if bus ();

    mem_io_responder #(.IO_BASE(8'hF0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.addr = 8'h00; bus.wdata = 8'h00; bus.write = 1'b0;
        bus.out_ready = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = 8'h00; bus.load_data = 8'h00;
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b want 1", bus.cpu_rst); end
        bus.addr = 8'hF2; #1;
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", bus.rdata); end
        bus.addr = 8'hF3; #1;
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_timer got %h want 00", bus.rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_loader();
        bus.load_en = 1'b1; bus.load_addr = 8'h10; bus.load_data = 8'hA5;
        tick();
        checks++;
        if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst_hold got %b want 1", bus.cpu_rst); end
        bus.load_addr = 8'hF0; bus.load_data = 8'h3C;
        tick();
        bus.load_en = 1'b0;
        #1;
        checks++;
        if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst_before_edge got %b want 1", bus.cpu_rst); end
        tick();
        checks++;
        if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL load_cpu_rst_release got %b want 0", bus.cpu_rst); end
        bus.addr = 8'h10; #1;
        checks++;
        if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL load_ram_10 got %h want a5", bus.rdata); end
        bus.addr = 8'hF0; #1;
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL load_io_shadow got %h want 00", bus.rdata); end
    endtask

    task automatic test_bus_write();
        bus.addr = 8'h20; bus.wdata = 8'h5A; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL bus_write_20 got %h want 5a", bus.rdata); end
        // Bus writes to RAM and the timer are both ignored while the loader runs.
        bus.load_en = 1'b1; bus.load_addr = 8'h11; bus.load_data = 8'h00;
        bus.addr = 8'h20; bus.wdata = 8'h77; bus.write = 1'b1;
        tick();
        bus.addr = 8'hF3; bus.wdata = 8'h80;
        tick();
        bus.write = 1'b0; bus.load_en = 1'b0;
        bus.addr = 8'h20; #1;
        checks++;
        if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL load_blocks_bus_write got %h want 5a", bus.rdata); end
        bus.addr = 8'hF0; #1;
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL load_blocks_io got %h want 00", bus.rdata); end
        tick();
    endtask

    task automatic test_out_port();
        bus.out_ready = 1'b0;
        bus.addr = 8'hF0; bus.wdata = 8'h11; bus.write = 1'b1;
        tick();
        bus.wdata = 8'h22;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.out_data !== 8'h11) begin errors++; $display("FAIL out_data_kept got %h want 11", bus.out_data); end
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid_set got %b want 1", bus.out_valid); end
        checks++;
        if (bus.rdata !== 8'h11) begin errors++; $display("FAIL out_readback got %h want 11", bus.rdata); end
        bus.addr = 8'hF2; #1;
        checks++;
        if (bus.rdata !== 8'h06) begin errors++; $display("FAIL status_overrun got %h want 06", bus.rdata); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL out_handshake got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'h11) begin errors++; $display("FAIL out_data_hold got %h want 11", bus.out_data); end
        checks++;
        if (bus.rdata !== 8'h04) begin errors++; $display("FAIL status_after_ack got %h want 04", bus.rdata); end
        bus.wdata = 8'h04; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL status_clear_overrun got %h want 00", bus.rdata); end
    endtask

    task automatic test_in_port();
        bus.in_valid = 1'b1; bus.in_data = 8'h7E; #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_idle got %b want 1", bus.in_ready); end
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_full got %b want 0", bus.in_ready); end
        bus.addr = 8'hF1; #1;
        checks++;
        if (bus.rdata !== 8'h7E) begin errors++; $display("FAIL in_hold_7e got %h want 7e", bus.rdata); end
        bus.addr = 8'hF2; #1;
        checks++;
        if (bus.rdata !== 8'h01) begin errors++; $display("FAIL status_in_full got %h want 01", bus.rdata); end
        bus.in_data = 8'h7F;
        tick();
        bus.addr = 8'hF1; #1;
        checks++;
        if (bus.rdata !== 8'h7E) begin errors++; $display("FAIL in_full_blocks got %h want 7e", bus.rdata); end
        bus.addr = 8'hF2; bus.wdata = 8'h01; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_clear_ready got %b want 1", bus.in_ready); end
        bus.addr = 8'hF1; #1;
        checks++;
        if (bus.rdata !== 8'h7E) begin errors++; $display("FAIL in_clear_no_take got %h want 7e", bus.rdata); end
        tick();
        checks++;
        if (bus.rdata !== 8'h7F) begin errors++; $display("FAIL in_take_7f got %h want 7f", bus.rdata); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_full_again got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_timer();
        bus.addr = 8'hF3; bus.wdata = 8'hFE; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.rdata !== 8'hFE) begin errors++; $display("FAIL timer_load got %h want fe", bus.rdata); end
        tick();
        checks++;
        if (bus.rdata !== 8'hFF) begin errors++; $display("FAIL timer_inc got %h want ff", bus.rdata); end
        tick();
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL timer_wrap got %h want 00", bus.rdata); end
        for (int a = 8'hF4; a <= 8'hFF; a++) begin
            bus.addr = 8'(a); #1;
            checks++;
            if (bus.rdata !== 8'h00) begin errors++; $display("FAIL unmapped_%h got %h want 00", a[7:0], bus.rdata); end
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.addr = 8'hF0; bus.wdata = 8'h33; bus.write = 1'b1;
        tick();
        bus.write = 1'b0; #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL pre_reset_state got valid=%b ready=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        bus.addr = 8'hF3;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL async_timer got %h want 00", bus.rdata); end
        checks++;
        if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL async_cpu_rst got %b want 1", bus.cpu_rst); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_loader();
        test_bus_write();
        test_out_port();
        test_in_port();
        test_timer();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
